// File: rtl/hwjsoc_irq_aggregator.sv
// hwjsoc_irq_aggregator
// Avalon-MM slave that gathers up to 16 peripheral interrupt lines into a
// pending register (per-source edge or level capture), masks them, and drives
// one registered irq to the CPU. A lowest-index-first HIGHEST register lets an
// ISR find its source with a single read.
//
// Register map (3-bit address, 16-bit data, registered readdata):
//   0 PENDING  read; write-1-to-clear on edge-mode bits
//   1 MASK     read/write; 1 = source enabled
//   2 MODE     read/write; 1 = edge, 0 = level
//   3 ACTIVE   read-only, PENDING & MASK
//   4 HIGHEST  read-only, {any_active, 11'b0, lowest active index}
//   5 FORCE    write-1-to-set PENDING on edge-mode bits; reads 0
//   6,7        reserved, read 0
//
// Build option: define HWJSOC_IRQ_SYNC_EN to pass every irq_in through a
// two-flop synchronizer (for asynchronous sources). Without it irq_in is used
// directly and all sources must be synchronous to clk.

module hwjsoc_irq_aggregator #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    // Bits at and above NUM_IRQ read as 0 and ignore writes.
    localparam logic [15:0] VALID_MASK =
        (NUM_IRQ >= 16) ? 16'hFFFF : 16'((32'd1 << NUM_IRQ) - 32'd1);

    typedef enum logic [2:0] {
        REG_PENDING = 3'd0,
        REG_MASK    = 3'd1,
        REG_MODE    = 3'd2,
        REG_ACTIVE  = 3'd3,
        REG_HIGHEST = 3'd4,
        REG_FORCE   = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_addr_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] pending_q, pending_d;
    logic [15:0] mask_q,    mask_d;
    logic [15:0] mode_q,    mode_d;
    logic [15:0] irq_prev_q;
    logic [15:0] readdata_q, readdata_d;
    logic        irq_q,      irq_d;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [15:0] irq_in_ext;
    logic [15:0] irq_s;

    assign irq_in_ext = 16'(irq_in);

`ifdef HWJSOC_IRQ_SYNC_EN
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;

    // Two-flop synchronizer for sources from other clock domains.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in_ext;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in_ext;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic wr_pending;
    logic wr_mask;
    logic wr_mode;
    logic wr_force;

    assign wr_en      = chipselect && !write_n;
    assign wr_pending = wr_en && (address == REG_PENDING);
    assign wr_mask    = wr_en && (address == REG_MASK);
    assign wr_mode    = wr_en && (address == REG_MODE);
    assign wr_force   = wr_en && (address == REG_FORCE);

    // ------------------------------------------------------------------
    // Pending / mask / mode next state
    // ------------------------------------------------------------------
    logic [15:0] rise;
    logic [15:0] edge_set;
    logic [15:0] edge_clr;
    logic [15:0] edge_next;

    // Edge bits: a set beats a same-cycle clear; level bits follow the input.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so
        // no latch can be inferred when a branch does not assign it.
        rise      = irq_s & ~irq_prev_q;
        edge_set  = rise | (wr_force ? writedata : 16'h0000);
        edge_clr  = wr_pending ? writedata : 16'h0000;
        edge_next = edge_set | (pending_q & ~edge_clr);
        pending_d = ((mode_q & edge_next) | (~mode_q & irq_s)) & VALID_MASK;

        mask_d = wr_mask ? (writedata & VALID_MASK) : mask_q;
        mode_d = wr_mode ? (writedata & VALID_MASK) : mode_q;
    end

    // ------------------------------------------------------------------
    // Priority encode (lowest active index wins)
    // ------------------------------------------------------------------
    logic [15:0] active;
    logic [3:0]  highest_idx;
    logic [15:0] highest_word;

    assign active = pending_q & mask_q;

    // Scan from the top so the last hit is the lowest-numbered active bit.
    always_comb begin
        highest_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) begin
                highest_idx = 4'(i);
            end
        end
    end

    assign highest_word = {|active, 11'b0, highest_idx};

    // ------------------------------------------------------------------
    // Read mux and combined irq
    // ------------------------------------------------------------------

    // Read data reflects register contents before any same-cycle write.
    always_comb begin
        readdata_d = 16'h0000;
        unique case (reg_addr_e'(address))
            REG_PENDING: readdata_d = pending_q;
            REG_MASK:    readdata_d = mask_q;
            REG_MODE:    readdata_d = mode_q;
            REG_ACTIVE:  readdata_d = active;
            REG_HIGHEST: readdata_d = highest_word;
            REG_FORCE:   readdata_d = 16'h0000;
            REG_RSVD6:   readdata_d = 16'h0000;
            REG_RSVD7:   readdata_d = 16'h0000;
        endcase
        irq_d = |active;
    end

    // All architectural state; reset wins over any concurrent bus write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: every register here is a handful of flops, so all of them
            // are reset; there is no storage array to leave uninitialised.
            pending_q  <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            irq_prev_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            irq_prev_q <= irq_s;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_hwjsoc_irq_aggregator.sv
// Self-checking bench for hwjsoc_irq_aggregator: a directed vector table,
// a few hand-written multi-cycle sequences, and a randomized run compared
// every cycle against a behavioural model of the register rules.

module tb_hwjsoc_irq_aggregator;

    localparam int N = 8;
`ifdef HWJSOC_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam logic [15:0] VALID = 16'((32'd1 << N) - 32'd1);

    logic          clk;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic [N-1:0]  irq_in;
    logic          irq;

    int n_tests;
    int n_fail;

    hwjsoc_irq_aggregator #(.NUM_IRQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [15:0] m_pend, m_mask, m_mode, m_prev, m_s1, m_s2, m_rd;
    logic        m_irq;

    function automatic logic [15:0] m_highest();
        logic [15:0] act;
        act = m_pend & m_mask;
        for (int i = 0; i < 16; i++) begin
            if (act[i]) return {1'b1, 11'b0, 4'(i)};
        end
        return 16'h0000;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_pend;
            3'd1:    return m_mask;
            3'd2:    return m_mode;
            3'd3:    return m_pend & m_mask;
            3'd4:    return m_highest();
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step();
        logic [15:0] src, np, nmask, nmode;
        logic        is_wr;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0;
            m_s1 = 0; m_s2 = 0; m_rd = 0; m_irq = 0;
        end else begin
            src   = (SYNC_LAT == 2) ? m_s2 : 16'(irq_in);
            is_wr = chipselect && !write_n;
            np    = m_pend;
            for (int i = 0; i < N; i++) begin
                if (m_mode[i]) begin
                    if ((src[i] && !m_prev[i]) || (is_wr && address == 3'd5 && writedata[i]))
                        np[i] = 1'b1;
                    else if (is_wr && address == 3'd0 && writedata[i])
                        np[i] = 1'b0;
                end else begin
                    np[i] = src[i];
                end
            end
            nmask = (is_wr && address == 3'd1) ? (writedata & VALID) : m_mask;
            nmode = (is_wr && address == 3'd2) ? (writedata & VALID) : m_mode;
            m_rd   = m_read(address);
            m_irq  = (m_pend & m_mask) != 0;
            m_pend = np;
            m_mask = nmask;
            m_mode = nmode;
            m_prev = src;
            m_s2   = m_s1;
            m_s1   = 16'(irq_in);
        end
    endtask

    // Advance one clock: model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic cs, input logic wn, input logic [2:0] a,
                         input logic [15:0] wd, input logic [N-1:0] iv);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        irq_in     = iv;
        tick();
    endtask

    task automatic rd(input logic [2:0] a, input logic [N-1:0] iv);
        drive(1'b0, 1'b0, 1'b1, a, 16'h0000, iv);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] wd, input logic [N-1:0] iv);
        drive(1'b0, 1'b1, 1'b0, a, wd, iv);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, '0);
        drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, '0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic         rst;
        logic         cs;
        logic         wn;
        logic [2:0]   addr;
        logic [15:0]  wd;
        logic [N-1:0] irqv;
        logic [15:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t vr(logic [2:0] a, logic [N-1:0] iv, logic [15:0] er, logic ei);
        return '{rst: 1'b0, cs: 1'b0, wn: 1'b1, addr: a, wd: 16'h0000, irqv: iv, exp_rd: er, exp_irq: ei};
    endfunction

    function automatic vec_t vw(logic [2:0] a, logic [15:0] wd, logic [N-1:0] iv, logic [15:0] er, logic ei);
        return '{rst: 1'b0, cs: 1'b1, wn: 1'b0, addr: a, wd: wd, irqv: iv, exp_rd: er, exp_irq: ei};
    endfunction

    task automatic fill_table();
        // Reset state: every address reads 0.
        for (int a = 0; a < 8; a++) vecs.push_back(vr(3'(a), 8'h00, 16'h0000, 1'b0));
        // Level source 0: pending after 1 edge, irq after 2, W1C has no effect.
        vecs.push_back(vw(3'd1, 16'h0001, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd0, 8'h01, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd0, 8'h01, 16'h0001, 1'b1));
        vecs.push_back(vw(3'd0, 16'h0001, 8'h01, 16'h0001, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0001, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0000, 1'b0));
        // Edge source 2: pulse latched, HIGHEST=0x8002, W1C clears.
        vecs.push_back(vw(3'd2, 16'h0004, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(vw(3'd1, 16'h0004, 8'h00, 16'h0001, 1'b0));
        vecs.push_back(vr(3'd0, 8'h04, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd4, 8'h00, 16'h8002, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0004, 1'b1));
        vecs.push_back(vw(3'd0, 16'h0004, 8'h00, 16'h0004, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0000, 1'b0));
        // Rising edge in the same cycle as W1C: the set wins.
        vecs.push_back(vr(3'd0, 8'h04, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0004, 1'b1));
        vecs.push_back(vw(3'd0, 16'h0004, 8'h04, 16'h0004, 1'b1));
        vecs.push_back(vr(3'd0, 8'h04, 16'h0004, 1'b1));
        vecs.push_back(vw(3'd0, 16'h0004, 8'h00, 16'h0004, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0000, 1'b0));
        // FORCE, ACTIVE and HIGHEST priority ordering.
        vecs.push_back(vw(3'd2, 16'h00FF, 8'h00, 16'h0004, 1'b0));
        vecs.push_back(vw(3'd1, 16'h0020, 8'h00, 16'h0004, 1'b0));
        vecs.push_back(vw(3'd5, 16'h0030, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0030, 1'b1));
        vecs.push_back(vr(3'd3, 8'h00, 16'h0020, 1'b1));
        vecs.push_back(vr(3'd4, 8'h00, 16'h8005, 1'b1));
        vecs.push_back(vw(3'd1, 16'h00FF, 8'h00, 16'h0020, 1'b1));
        vecs.push_back(vr(3'd4, 8'h00, 16'h8004, 1'b1));
        // Upper bits ignored, reserved addresses, unselected write.
        vecs.push_back(vw(3'd1, 16'hFFFF, 8'h00, 16'h00FF, 1'b1));
        vecs.push_back(vr(3'd1, 8'h00, 16'h00FF, 1'b1));
        vecs.push_back(vw(3'd6, 16'hFFFF, 8'h00, 16'h0000, 1'b1));
        vecs.push_back(vr(3'd7, 8'h00, 16'h0000, 1'b1));
        vecs.push_back('{rst: 1'b0, cs: 1'b0, wn: 1'b0, addr: 3'd1, wd: 16'h0000, irqv: 8'h00,
                         exp_rd: 16'h00FF, exp_irq: 1'b1});
        vecs.push_back(vr(3'd1, 8'h00, 16'h00FF, 1'b1));
        // Partial W1C leaves bit 5; HIGHEST moves back to 5.
        vecs.push_back(vw(3'd0, 16'h0010, 8'h00, 16'h0030, 1'b1));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0020, 1'b1));
        vecs.push_back(vr(3'd4, 8'h00, 16'h8005, 1'b1));
        // Reset mid-operation beats a concurrent MASK write.
        vecs.push_back('{rst: 1'b1, cs: 1'b1, wn: 1'b0, addr: 3'd1, wd: 16'h0001, irqv: 8'h00,
                         exp_rd: 16'h0000, exp_irq: 1'b0});
        vecs.push_back(vr(3'd1, 8'h00, 16'h0000, 1'b0));
        vecs.push_back(vr(3'd0, 8'h00, 16'h0000, 1'b0));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'h0000;
        irq_in     = '0;

        do_reset();
        check("reset_readdata", readdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);

`ifndef HWJSOC_IRQ_SYNC_EN
        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd, vecs[i].irqv);
            check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {15'b0, irq}, {15'b0, vecs[i].exp_irq});
        end

        // Edge->level switch re-samples the (low) input.
        do_reset();
        wr(3'd2, 16'h0002, 8'h00);
        wr(3'd5, 16'h0002, 8'h00);
        wr(3'd2, 16'h0000, 8'h00);
        rd(3'd0, 8'h00);
        check("e2l_pending_before", readdata, 16'h0002);
        rd(3'd0, 8'h00);
        check("e2l_pending_resampled", readdata, 16'h0000);

        // Level->edge switch keeps the captured value until cleared.
        rd(3'd0, 8'h02);
        wr(3'd2, 16'h0002, 8'h02);
        rd(3'd0, 8'h00);
        rd(3'd0, 8'h00);
        check("l2e_pending_kept", readdata, 16'h0002);
        wr(3'd0, 16'h0002, 8'h00);
        rd(3'd0, 8'h00);
        check("l2e_pending_cleared", readdata, 16'h0000);
`else
        // Synchronized level source: rise before edge k gives irq after k+3.
        wr(3'd1, 16'h0001, 8'h00);
        rd(3'd0, 8'h01);
        check("sync_irq_k", {15'b0, irq}, 16'h0000);
        rd(3'd0, 8'h01);
        check("sync_irq_k1", {15'b0, irq}, 16'h0000);
        rd(3'd0, 8'h01);
        check("sync_irq_k2", {15'b0, irq}, 16'h0000);
        rd(3'd0, 8'h01);
        check("sync_irq_k3", {15'b0, irq}, 16'h0001);
        check("sync_pending", readdata, 16'h0001);
        drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 8'h01);
        check("sync_reset_irq", {15'b0, irq}, 16'h0000);
        rd(3'd0, 8'h01);
        check("sync_reset_pending", readdata, 16'h0000);
        rd(3'd1, 8'h01);
        check("sync_reset_mask", readdata, 16'h0000);
`endif

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 1) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'($urandom) & VALID);
            if ($urandom_range(0, 2) == 0)
                irq_in = irq_in ^ N'(1 << $urandom_range(0, N - 1));
            tick();
            check("rnd_readdata", readdata, m_rd);
            check("rnd_irq", {15'b0, irq}, {15'b0, m_irq});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
